// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: tag/opcode/PC widths used by rename,
// the issue queue and execute, plus the issue-queue entry layout and the
// CDB tag-match helpers.
package ooo_pkg;

  localparam int IQ_DEPTH = 8;
  localparam int PREG_W   = 5;
  localparam int OP_W     = 4;
  localparam int PC_W     = 32;

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [OP_W-1:0]   op;
    logic [PREG_W-1:0] prs1;
    logic              rdy1;
    logic [PREG_W-1:0] prs2;
    logic              rdy2;
    logic [PREG_W-1:0] prd;
  } iq_entry_t;

  localparam iq_entry_t IQ_ENTRY_EMPTY = '0;

  // Tag 0 is the hardwired-zero register, so a broadcast of tag 0 never wakes anything.
  function automatic logic cdb_hit(input logic              en,
                                   input logic [PREG_W-1:0] cdb_tag,
                                   input logic [PREG_W-1:0] tag);
    return en && (cdb_tag != {PREG_W{1'b0}}) && (cdb_tag == tag);
  endfunction

  // Source readiness for a newly allocated entry, including same-cycle CDB bypass.
  function automatic logic src_ready_at_alloc(input logic              busy_ready,
                                              input logic [PREG_W-1:0] tag,
                                              input logic              en,
                                              input logic [PREG_W-1:0] cdb_tag);
    return busy_ready || (tag == {PREG_W{1'b0}}) || cdb_hit(en, cdb_tag, tag);
  endfunction

endpackage

// File: rtl/iq_select.sv
// Oldest-first picker for the issue queue: isolates the lowest set request
// bit as a one-hot grant and reports its index.
module iq_select #(
  parameter int DEPTH = 8,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  // Lowest-index request wins: one-hot grant plus the encoded index of that bit.
  always_comb begin
    grant     = req & (~req + {{(DEPTH-1){1'b0}}, 1'b1});
    grant_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      grant_idx = req[i] ? IDX_W'(i) : grant_idx;
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Collapsing reservation station between rename and the single execute port.
// Index 0 always holds the oldest entry; an issued entry is removed and every
// younger entry shifts down one slot, new entries land just above the survivors.
module issue_queue
  import ooo_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              inst_valid_i,
  output logic              inst_ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [PREG_W-1:0] prs1_addr_i,
  input  logic [PREG_W-1:0] prs2_addr_i,
  input  logic [PREG_W-1:0] prd_addr_i,
  input  logic              prs1_ready_i,
  input  logic              prs2_ready_i,
  input  logic              cdb_en_i,
  input  logic [PREG_W-1:0] cdb_reg_addr_i,
  output logic              issue_valid_o,
  input  logic              issue_ready_i,
  output logic [PC_W-1:0]   issue_pc_o,
  output logic [OP_W-1:0]   issue_op_o,
  output logic [PREG_W-1:0] issue_prs1_addr_o,
  output logic [PREG_W-1:0] issue_prs2_addr_o,
  output logic [PREG_W-1:0] issue_prd_addr_o,
  output logic [CNT_W-1:0]  count_o
);

  iq_entry_t        entries_r [DEPTH];
  iq_entry_t        shift_s   [DEPTH];
  iq_entry_t        woken_s   [DEPTH];
  iq_entry_t        entries_nxt_s [DEPTH];
  iq_entry_t        issue_entry_s;
  iq_entry_t        new_entry_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [CNT_W-1:0] tail_s;
  logic [DEPTH-1:0] sel_req_s;
  logic [DEPTH-1:0] sel_grant_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic             issue_fire_s;
  logic             alloc_fire_s;

  // Only entries whose both sources are marked ready (registered bits) may be picked.
  always_comb begin
    sel_req_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_req_s[i] = entries_r[i].valid & entries_r[i].rdy1 & entries_r[i].rdy2;
    end
  end

  iq_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .req       (sel_req_s),
    .grant     (sel_grant_s),
    .grant_idx (sel_idx_s)
  );

  // One-hot mux of the granted entry; all-zero when nothing is selectable.
  always_comb begin
    issue_entry_s = IQ_ENTRY_EMPTY;
    for (int i = 0; i < DEPTH; i++) begin
      issue_entry_s = sel_grant_s[i] ? entries_r[i] : issue_entry_s;
    end
  end

  // Drive the execute-port view and the handshake qualifiers.
  always_comb begin
    issue_valid_o     = issue_entry_s.valid & issue_entry_s.rdy1 & issue_entry_s.rdy2;
    issue_pc_o        = issue_entry_s.pc;
    issue_op_o        = issue_entry_s.op;
    issue_prs1_addr_o = issue_entry_s.prs1;
    issue_prs2_addr_o = issue_entry_s.prs2;
    issue_prd_addr_o  = issue_entry_s.prd;
    count_o           = count_r;
    inst_ready_o      = (count_r < CNT_W'(DEPTH));
    issue_fire_s      = issue_valid_o & issue_ready_i;
    alloc_fire_s      = inst_valid_i & inst_ready_o;
    tail_s            = count_r - CNT_W'(issue_fire_s);
    count_nxt_s       = count_r - CNT_W'(issue_fire_s) + CNT_W'(alloc_fire_s);
  end

  // Build the incoming entry, folding in busy-table, tag-0 and same-cycle CDB readiness.
  always_comb begin
    new_entry_s       = IQ_ENTRY_EMPTY;
    new_entry_s.valid = 1'b1;
    new_entry_s.pc    = pc_i;
    new_entry_s.op    = op_i;
    new_entry_s.prs1  = prs1_addr_i;
    new_entry_s.prs2  = prs2_addr_i;
    new_entry_s.prd   = prd_addr_i;
    new_entry_s.rdy1  = src_ready_at_alloc(prs1_ready_i, prs1_addr_i, cdb_en_i, cdb_reg_addr_i);
    new_entry_s.rdy2  = src_ready_at_alloc(prs2_ready_i, prs2_addr_i, cdb_en_i, cdb_reg_addr_i);
  end

  // Collapse: on issue, every slot at or above the granted index takes its upper neighbour.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      shift_s[i] = (issue_fire_s && (IDX_W'(i) >= sel_idx_s)) ? entries_r[i + 1] : entries_r[i];
    end
    shift_s[DEPTH-1] = issue_fire_s ? IQ_ENTRY_EMPTY : entries_r[DEPTH-1];
  end

  // Wakeup: a CDB broadcast sets the ready bit of every matching source of a live entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken_s[i]      = shift_s[i];
      woken_s[i].rdy1 = shift_s[i].rdy1 |
                        (shift_s[i].valid & cdb_hit(cdb_en_i, cdb_reg_addr_i, shift_s[i].prs1));
      woken_s[i].rdy2 = shift_s[i].rdy2 |
                        (shift_s[i].valid & cdb_hit(cdb_en_i, cdb_reg_addr_i, shift_s[i].prs2));
    end
  end

  // Allocate: the new entry goes to the first free slot after this cycle's removal.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_nxt_s[i] = (alloc_fire_s && (CNT_W'(i) == tail_s)) ? new_entry_s : woken_s[i];
    end
  end

  // Queue state: reset and flush empty the queue and override any same-cycle activity.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= IQ_ENTRY_EMPTY;
      end
      count_r <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= entries_nxt_s[i];
      end
      count_r <= count_nxt_s;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: a queue-based age-ordered model is
// checked against the DUT on every falling edge, and directed scenarios add
// hand-computed literal expectations.
module tb_issue_queue;
  import ooo_pkg::*;

  localparam int DEPTH = 8;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              flush_i;
  logic              inst_valid_i;
  logic              inst_ready_o;
  logic [PC_W-1:0]   pc_i;
  logic [OP_W-1:0]   op_i;
  logic [PREG_W-1:0] prs1_addr_i;
  logic [PREG_W-1:0] prs2_addr_i;
  logic [PREG_W-1:0] prd_addr_i;
  logic              prs1_ready_i;
  logic              prs2_ready_i;
  logic              cdb_en_i;
  logic [PREG_W-1:0] cdb_reg_addr_i;
  logic              issue_valid_o;
  logic              issue_ready_i;
  logic [PC_W-1:0]   issue_pc_o;
  logic [OP_W-1:0]   issue_op_o;
  logic [PREG_W-1:0] issue_prs1_addr_o;
  logic [PREG_W-1:0] issue_prs2_addr_o;
  logic [PREG_W-1:0] issue_prd_addr_o;
  logic [3:0]        count_o;

  always #5 clk_i = ~clk_i;

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .flush_i           (flush_i),
    .inst_valid_i      (inst_valid_i),
    .inst_ready_o      (inst_ready_o),
    .pc_i              (pc_i),
    .op_i              (op_i),
    .prs1_addr_i       (prs1_addr_i),
    .prs2_addr_i       (prs2_addr_i),
    .prd_addr_i        (prd_addr_i),
    .prs1_ready_i      (prs1_ready_i),
    .prs2_ready_i      (prs2_ready_i),
    .cdb_en_i          (cdb_en_i),
    .cdb_reg_addr_i    (cdb_reg_addr_i),
    .issue_valid_o     (issue_valid_o),
    .issue_ready_i     (issue_ready_i),
    .issue_pc_o        (issue_pc_o),
    .issue_op_o        (issue_op_o),
    .issue_prs1_addr_o (issue_prs1_addr_o),
    .issue_prs2_addr_o (issue_prs2_addr_o),
    .issue_prd_addr_o  (issue_prd_addr_o),
    .count_o           (count_o)
  );

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [OP_W-1:0]   op;
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [PREG_W-1:0] prd;
    bit                r1;
    bit                r2;
  } mdl_t;

  mdl_t mq[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  bit   chk_en       = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Oldest model entry with both sources ready, or -1.
  function automatic int mdl_sel();
    for (int k = 0; k < mq.size(); k++) begin
      if (mq[k].r1 && mq[k].r2) return k;
    end
    return -1;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void mdl_step();
    int   s;
    bit   issued;
    bit   acc;
    mdl_t n;
    if (reset_i || flush_i) begin
      mq.delete();
      return;
    end
    s      = mdl_sel();
    issued = (s >= 0) && issue_ready_i;
    acc    = inst_valid_i && (mq.size() < DEPTH);
    if (cdb_en_i && cdb_reg_addr_i != 5'd0) begin
      foreach (mq[k]) begin
        if (mq[k].prs1 == cdb_reg_addr_i) mq[k].r1 = 1'b1;
        if (mq[k].prs2 == cdb_reg_addr_i) mq[k].r2 = 1'b1;
      end
    end
    if (issued) mq.delete(s);
    if (acc) begin
      n.pc   = pc_i;
      n.op   = op_i;
      n.prs1 = prs1_addr_i;
      n.prs2 = prs2_addr_i;
      n.prd  = prd_addr_i;
      n.r1   = prs1_ready_i || (prs1_addr_i == 5'd0) ||
               (cdb_en_i && cdb_reg_addr_i != 5'd0 && cdb_reg_addr_i == prs1_addr_i);
      n.r2   = prs2_ready_i || (prs2_addr_i == 5'd0) ||
               (cdb_en_i && cdb_reg_addr_i != 5'd0 && cdb_reg_addr_i == prs2_addr_i);
      mq.push_back(n);
    end
  endfunction

  task automatic tick();
    @(posedge clk_i);
    mdl_step();
    #1;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [3:0] op,
                       input logic [4:0] p1, input logic r1,
                       input logic [4:0] p2, input logic r2, input logic [4:0] prd);
    inst_valid_i = 1'b1;
    pc_i         = pc;
    op_i         = op;
    prs1_addr_i  = p1;
    prs1_ready_i = r1;
    prs2_addr_i  = p2;
    prs2_ready_i = r2;
    prd_addr_i   = prd;
  endtask

  task automatic idle();
    inst_valid_i = 1'b0;
    cdb_en_i     = 1'b0;
  endtask

  // Every-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge clk_i) begin
    int s;
    if (chk_en) begin
      s = mdl_sel();
      chk("count", 64'(count_o), 64'(mq.size()));
      chk("inst_ready", 64'(inst_ready_o), 64'(mq.size() < DEPTH));
      chk("issue_valid", 64'(issue_valid_o), 64'(s >= 0));
      if (s >= 0) begin
        chk("issue_pc", 64'(issue_pc_o), 64'(mq[s].pc));
        chk("issue_op", 64'(issue_op_o), 64'(mq[s].op));
        chk("issue_prs1", 64'(issue_prs1_addr_o), 64'(mq[s].prs1));
        chk("issue_prs2", 64'(issue_prs2_addr_o), 64'(mq[s].prs2));
        chk("issue_prd", 64'(issue_prd_addr_o), 64'(mq[s].prd));
      end else begin
        chk("idle_pc", 64'(issue_pc_o), 64'd0);
        chk("idle_op", 64'(issue_op_o), 64'd0);
        chk("idle_prs1", 64'(issue_prs1_addr_o), 64'd0);
        chk("idle_prs2", 64'(issue_prs2_addr_o), 64'd0);
        chk("idle_prd", 64'(issue_prd_addr_o), 64'd0);
      end
    end
  end

  initial begin
    reset_i        = 1'b1;
    flush_i        = 1'b0;
    inst_valid_i   = 1'b0;
    pc_i           = 32'd0;
    op_i           = 4'd0;
    prs1_addr_i    = 5'd0;
    prs2_addr_i    = 5'd0;
    prd_addr_i     = 5'd0;
    prs1_ready_i   = 1'b0;
    prs2_ready_i   = 1'b0;
    cdb_en_i       = 1'b0;
    cdb_reg_addr_i = 5'd0;
    issue_ready_i  = 1'b1;
    tick();
    tick();
    chk_en  = 1'b1;
    reset_i = 1'b0;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_inst_ready", 64'(inst_ready_o), 64'd1);
    chk("rst_issue_valid", 64'(issue_valid_o), 64'd0);
    chk("rst_issue_prd", 64'(issue_prd_addr_o), 64'd0);

    // Single always-ready instruction: issues the cycle after allocation.
    alloc(32'h0, 4'h1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1);
    tick();
    idle();
    chk("t1_valid", 64'(issue_valid_o), 64'd1);
    chk("t1_prd", 64'(issue_prd_addr_o), 64'd1);
    chk("t1_count", 64'(count_o), 64'd1);
    tick();
    chk("t1_count_after", 64'(count_o), 64'd0);
    chk("t1_valid_after", 64'(issue_valid_o), 64'd0);

    // Younger ready B overtakes older unready A; CDB tag 5 then releases A.
    alloc(32'h100, 4'h2, 5'd5, 1'b0, 5'd0, 1'b0, 5'd2);
    tick();
    chk("t2_a_blocked", 64'(issue_valid_o), 64'd0);
    alloc(32'h104, 4'h3, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6);
    tick();
    idle();
    chk("t2_b_pc", 64'(issue_pc_o), 64'h104);
    chk("t2_b_prd", 64'(issue_prd_addr_o), 64'd6);
    chk("t2_count2", 64'(count_o), 64'd2);
    tick();
    chk("t2_count1", 64'(count_o), 64'd1);
    chk("t2_a_waiting", 64'(issue_valid_o), 64'd0);
    cdb_en_i       = 1'b1;
    cdb_reg_addr_i = 5'd5;
    tick();
    idle();
    chk("t2_a_valid", 64'(issue_valid_o), 64'd1);
    chk("t2_a_pc", 64'(issue_pc_o), 64'h100);
    tick();
    chk("t2_empty", 64'(count_o), 64'd0);

    // Fill with entries waiting on tag 7, refuse a 9th, then drain in age order.
    for (int k = 0; k < 8; k++) begin
      alloc(32'h200 + 32'(4 * k), 4'(k), 5'd7, 1'b0, 5'd0, 1'b1, 5'(8 + k));
      tick();
    end
    chk("t3_full_count", 64'(count_o), 64'd8);
    chk("t3_full_ready", 64'(inst_ready_o), 64'd0);
    alloc(32'h300, 4'h0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd20);
    tick();
    idle();
    chk("t3_ninth_count", 64'(count_o), 64'd8);
    chk("t3_ninth_valid", 64'(issue_valid_o), 64'd0);
    cdb_en_i       = 1'b1;
    cdb_reg_addr_i = 5'd7;
    tick();
    idle();
    for (int k = 0; k < 8; k++) begin
      chk("t3_drain_pc", 64'(issue_pc_o), 64'h200 + 64'(4 * k));
      chk("t3_drain_count", 64'(count_o), 64'(8 - k));
      tick();
    end
    chk("t3_drained", 64'(count_o), 64'd0);

    // Same-cycle CDB bypass into the entry being allocated.
    cdb_en_i       = 1'b1;
    cdb_reg_addr_i = 5'd9;
    alloc(32'h400, 4'h5, 5'd9, 1'b0, 5'd0, 1'b0, 5'd10);
    tick();
    idle();
    chk("t4_valid", 64'(issue_valid_o), 64'd1);
    chk("t4_pc", 64'(issue_pc_o), 64'h400);
    tick();
    chk("t4_empty", 64'(count_o), 64'd0);

    // Execute stalls: outputs and count hold.
    issue_ready_i = 1'b0;
    alloc(32'h500, 4'h6, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3);
    tick();
    idle();
    for (int r = 0; r < 3; r++) begin
      chk("t5_hold_pc", 64'(issue_pc_o), 64'h500);
      chk("t5_hold_prd", 64'(issue_prd_addr_o), 64'd3);
      chk("t5_hold_count", 64'(count_o), 64'd1);
      tick();
    end
    issue_ready_i = 1'b1;
    tick();
    chk("t5_released", 64'(count_o), 64'd0);

    // While stalled, an older entry waking up takes over the issue port.
    issue_ready_i = 1'b0;
    alloc(32'h600, 4'h7, 5'd11, 1'b0, 5'd0, 1'b0, 5'd4);
    tick();
    alloc(32'h604, 4'h8, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5);
    tick();
    idle();
    chk("t5_young_pc", 64'(issue_pc_o), 64'h604);
    cdb_en_i       = 1'b1;
    cdb_reg_addr_i = 5'd11;
    tick();
    idle();
    chk("t5_old_pc", 64'(issue_pc_o), 64'h600);
    chk("t5_old_count", 64'(count_o), 64'd2);
    issue_ready_i = 1'b1;
    tick();
    tick();
    chk("t5_empty", 64'(count_o), 64'd0);

    // Flush with four entries and a simultaneous allocation.
    for (int k = 0; k < 4; k++) begin
      alloc(32'h700 + 32'(4 * k), 4'h9, 5'd12, 1'b0, 5'd0, 1'b1, 5'(k));
      tick();
    end
    chk("t6_count4", 64'(count_o), 64'd4);
    flush_i = 1'b1;
    alloc(32'h800, 4'h0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1);
    tick();
    flush_i = 1'b0;
    idle();
    chk("t6_count", 64'(count_o), 64'd0);
    chk("t6_valid", 64'(issue_valid_o), 64'd0);
    chk("t6_ready", 64'(inst_ready_o), 64'd1);

    // Mixed traffic: overlapping allocate, wakeup, stall and issue, checked by the model.
    for (int c = 0; c < 60; c++) begin
      inst_valid_i   = (c % 3 != 2);
      pc_i           = 32'h1000 + 32'(4 * c);
      op_i           = 4'(c);
      prs1_addr_i    = 5'((c % 5) + 1);
      prs1_ready_i   = (c % 4 == 0);
      prs2_addr_i    = 5'(c % 3);
      prs2_ready_i   = 1'b0;
      prd_addr_i     = 5'(c);
      cdb_en_i       = (c % 3 != 0);
      cdb_reg_addr_i = 5'((c / 2) % 6);
      issue_ready_i  = (c % 7 != 3);
      tick();
    end
    idle();
    issue_ready_i = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      cdb_en_i       = 1'b1;
      cdb_reg_addr_i = 5'(t);
      tick();
    end
    cdb_en_i = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
    end
    chk("mix_drained", 64'(count_o), 64'd0);

    @(negedge clk_i);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
